// File: rtl/frame_mem_pkg.sv
// Shared constants for the frame block RAM and its requesters.
package frame_mem_pkg;

  localparam int FRAME_AW    = 16;
  localparam int FRAME_DW    = 8;
  localparam int BRAM_RD_LAT = 2;

  localparam int REQ_LOADER = 0;
  localparam int REQ_PEAK   = 1;
  localparam int REQ_ROI    = 2;

  // Index visited k steps after 'last' in a ring of n requesters.
  function automatic int rr_next(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter with a one-hot combinational grant.
// The pointer holds the most recently granted index; the search for the
// next winner starts one position after it.
module rr_arbiter
  import frame_mem_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_cand;
  logic          w_any;

  // Scan the ring starting after r_last, first asserted request wins.
  always_comb begin
    w_idx  = '0;
    w_cand = '0;
    w_any  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'(rr_next(int'(r_last), k, N));
      if (!w_any && req[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
  end

  // One-hot grant vector built from the winning index.
  always_comb begin
    gnt = '0;
    if (w_any) gnt[w_idx] = 1'b1;
  end

  assign gnt_idx = w_idx;
  assign gnt_any = w_any;

  // Pointer update; reset leaves N-1 so index 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IW'(N - 1);
    end else if (advance && w_any) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares the single BRAM port between NREQ requesters. One command is
// accepted per cycle, registered onto the BRAM pins, and reads are tagged
// with the requester index so the returning data is steered back to it.
module bram_port_arbiter
  import frame_mem_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int AW     = FRAME_AW,
  parameter int DW     = FRAME_DW,
  parameter int RD_LAT = BRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [AW-1:0]     bram_addra,
  output logic [DW-1:0]     bram_dina,
  input  logic [DW-1:0]     bram_douta
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_gnt_any;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  logic            r_ena;
  logic            r_wea;
  logic [AW-1:0]   r_addra;
  logic [DW-1:0]   r_dina;

  logic [RD_LAT-1:0]         r_tag_vld;
  logic [RD_LAT-1:0][IW-1:0] r_tag_idx;

  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (1'b1),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  // Select the granted requester's command fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*AW +: AW];
        w_sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Issue stage: register the granted command onto the BRAM pins.
  // Address and data hold when idle so the pins do not toggle needlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ena   <= 1'b0;
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
    end else begin
      r_ena <= w_gnt_any;
      r_wea <= w_gnt_any & w_sel_we;
      if (w_gnt_any) begin
        r_addra <= w_sel_addr;
        r_dina  <= w_sel_wdata;
      end
    end
  end

  // Read-tag shift register, loaded in step with the issue stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
      r_tag_vld[0] <= w_gnt_any & ~w_sel_we;
      r_tag_idx[0] <= w_gnt_idx;
    end
  end

  // Return stage: capture douta and strobe the owning requester.
  // rdata only updates on a return so it stays stable between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (r_tag_vld[RD_LAT-1]) begin
        r_rvalid[r_tag_idx[RD_LAT-1]] <= 1'b1;
        r_rdata                       <= bram_douta;
      end
    end
  end

  assign gnt        = w_gnt;
  assign rvalid     = r_rvalid;
  assign rdata      = r_rdata;
  assign bram_ena   = r_ena;
  assign bram_wea   = r_wea;
  assign bram_addra = r_addra;
  assign bram_dina  = r_dina;

  // The return stage counts as in flight: busy spans gnt+1 through the
  // rvalid cycle, so a client can wait on busy falling for a full drain.
  assign busy = r_ena | (|r_tag_vld) | (|r_rvalid);

endmodule
